// File: rtl/gc_sched.sv
// gc_sched: fork/join loop-index scheduler handing out strided indices to N_CORE cores
module gc_sched #(
    parameter int N_CORE   = 4,
    parameter int GC_WIDTH = 32,
    parameter int GD_WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_fork_valid,
    output logic                       o_fork_ready,
    input  logic [GC_WIDTH-1:0]        i_fork_gc,
    input  logic [GD_WIDTH-1:0]        i_fork_gd,
    input  logic [GC_WIDTH-1:0]        i_fork_limit,
    input  logic [N_CORE-1:0]          i_req_valid,
    output logic [N_CORE-1:0]          o_req_ready,
    output logic [N_CORE*GC_WIDTH-1:0] o_req_idx,
    output logic [N_CORE-1:0]          o_req_exhausted,
    input  logic [N_CORE-1:0]          i_core_idle,
    output logic                       o_join_valid,
    output logic                       o_busy,
    output logic [GC_WIDTH-1:0]        o_issued_count
);
    localparam int KW = $clog2(N_CORE + 1);
    localparam int EW = GC_WIDTH + KW + 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, JOIN} state_t;
    state_t                     r_state, w_state_nx;
    logic signed [GC_WIDTH-1:0] r_gc, r_limit;
    logic signed [GD_WIDTH-1:0] r_gd;
    logic [GC_WIDTH-1:0]        r_issued;
    logic signed [EW-1:0]       w_gc_x, w_gd_x, w_lim_x;
    logic signed [EW-1:0]       w_cand [N_CORE+1];
    logic [N_CORE:0]            w_inr;
    logic [KW-1:0]              w_k, w_n;
    logic                       w_gd_pos, w_gd_neg;
    assign w_gc_x         = EW'(r_gc);
    assign w_gd_x         = EW'(r_gd);
    assign w_lim_x        = EW'(r_limit);
    assign w_gd_neg       = r_gd[GD_WIDTH-1];
    assign w_gd_pos       = !w_gd_neg && (r_gd != '0);
    assign o_fork_ready   = (r_state == IDLE);
    assign o_busy         = (r_state != IDLE);
    assign o_join_valid   = (r_state == JOIN);
    assign o_issued_count = r_issued;
    // candidate k is the index the k-th valid requester would receive; wide enough never to wrap
    for (genvar k = 0; k <= N_CORE; k++) begin : g_cand
        assign w_cand[k] = w_gc_x + w_gd_x * EW'(k);
        assign w_inr[k]  = w_gd_pos ? (w_cand[k] < w_lim_x) : (w_gd_neg && (w_cand[k] > w_lim_x));
    end
    // per-core grants in priority order plus next-state selection
    always_comb begin
        w_state_nx      = r_state;
        o_req_ready     = '0;
        o_req_exhausted = '0;
        o_req_idx       = '0;
        w_k             = '0;
        w_n             = '0;
        for (int i = 0; i < N_CORE; i++) begin
            if (i_req_valid[i] && (r_state == RUN)) begin
                o_req_ready[i]                    = 1'b1;
                o_req_idx[i*GC_WIDTH +: GC_WIDTH] = w_cand[w_k][GC_WIDTH-1:0];
                o_req_exhausted[i]                = !w_inr[w_k];
                w_n                               = w_n + KW'(w_inr[w_k]);
                w_k                               = w_k + KW'(1);
            end else if (i_req_valid[i] && (r_state == DRAIN)) begin
                o_req_ready[i]     = 1'b1;
                o_req_exhausted[i] = 1'b1;
            end
        end
        case (r_state)
            IDLE:    w_state_nx = i_fork_valid ? RUN : IDLE;
            RUN:     w_state_nx = ((|o_req_exhausted) || !w_inr[w_n]) ? DRAIN : RUN;
            DRAIN:   w_state_nx = ((&i_core_idle) && !(|i_req_valid)) ? JOIN : DRAIN;
            default: w_state_nx = IDLE;
        endcase
    end
    // state, loop registers and issue counter; fork accepted only in IDLE
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_gc     <= '0;
            r_gd     <= '0;
            r_limit  <= '0;
            r_issued <= '0;
        end else begin
            r_state <= w_state_nx;
            if ((r_state == IDLE) && i_fork_valid) begin
                r_gc     <= i_fork_gc;
                r_gd     <= i_fork_gd;
                r_limit  <= i_fork_limit;
                r_issued <= '0;
            end else if (r_state == RUN) begin
                r_gc     <= w_cand[w_n][GC_WIDTH-1:0];
                r_issued <= r_issued + GC_WIDTH'(w_n);
            end
        end
    end
endmodule

// File: tb/tb_gc_sched.sv
// tb_gc_sched: scoreboard bench for gc_sched with directed loop scenarios
module tb_gc_sched;
    localparam int N = 4;
    localparam int W = 32;
    typedef struct packed {
        logic [N-1:0]   rdy;
        logic [N-1:0]   exh;
        logic [N*W-1:0] idx;
    } exp_t;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           fork_valid = 1'b0;
    logic           fork_ready;
    logic [W-1:0]   fork_gc = '0;
    logic [W-1:0]   fork_gd = '0;
    logic [W-1:0]   fork_limit = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_idx;
    logic [N-1:0]   req_exhausted;
    logic [N-1:0]   core_idle = '0;
    logic           join_valid;
    logic           busy;
    logic [W-1:0]   issued_count;
    exp_t           q[$];
    exp_t           m_e;
    int             tests = 0;
    int             fails = 0;
    int             joins = 0;

    gc_sched #(.N_CORE(N), .GC_WIDTH(W), .GD_WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fork_valid(fork_valid), .o_fork_ready(fork_ready),
        .i_fork_gc(fork_gc), .i_fork_gd(fork_gd), .i_fork_limit(fork_limit),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .o_req_idx(req_idx),
        .o_req_exhausted(req_exhausted), .i_core_idle(core_idle),
        .o_join_valid(join_valid), .o_busy(busy), .o_issued_count(issued_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [N-1:0] v, input logic [N-1:0] r, input logic [N-1:0] x,
                       input logic [N*W-1:0] idx);
        exp_t e;
        e.rdy = r;
        e.exh = x;
        e.idx = idx;
        q.push_back(e);
        req_valid = v;
        step();
        req_valid = '0;
    endtask

    task automatic do_fork(input logic [W-1:0] gc, input logic [W-1:0] gd, input logic [W-1:0] lim,
                           input bit hold);
        fork_gc    = gc;
        fork_gd    = gd;
        fork_limit = lim;
        fork_valid = 1'b1;
        #1;
        chk("fork_ready_idle", fork_ready, 1);
        step();
        if (!hold) fork_valid = 1'b0;
        chk("busy_after_fork", busy, 1);
        chk("issued_after_fork", issued_count, 0);
    endtask

    task automatic finish_loop();
        core_idle = '1;
        step();
        chk("join_pulse", join_valid, 1);
        chk("join_no_fork_ready", fork_ready, 0);
        step();
        chk("join_single", join_valid, 0);
        chk("idle_fork_ready", fork_ready, 1);
        chk("idle_not_busy", busy, 0);
        core_idle = '0;
    endtask

    // monitor: every cycle the DUT strobes req_ready, pop the oldest expectation and compare
    always @(negedge clk) begin
        if (join_valid) joins++;
        if (req_ready != '0) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: ready=%b with no expected entry", req_ready);
            end else begin
                m_e = q.pop_front();
                chk("resp_ready", req_ready, m_e.rdy);
                chk("resp_exhausted", req_exhausted, m_e.exh);
                for (int i = 0; i < N; i++)
                    if (m_e.rdy[i]) chk("resp_idx", req_idx[i*W +: W], m_e.idx[i*W +: W]);
            end
        end
    end

    initial begin
        repeat (2) step();
        chk("rst_fork_ready", fork_ready, 1);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_exhausted", req_exhausted, 0);
        chk("rst_join", join_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issued", issued_count, 0);
        rst_n = 1'b1;
        req_valid = '1;
        #1;
        chk("idle_stall_ready", req_ready, 0);
        step();
        req_valid = '0;
        // ascending loop, all four cores
        do_fork(0, 1, 10, 0);
        req(4'hF, 4'hF, 4'h0, pk(0, 1, 2, 3));
        req(4'hF, 4'hF, 4'h0, pk(4, 5, 6, 7));
        req(4'hF, 4'hF, 4'hC, pk(8, 9, 10, 11));
        chk("t1_issued", issued_count, 10);
        chk("t1_drain_fork_ready", fork_ready, 0);
        req(4'hF, 4'hF, 4'hF, pk(0, 0, 0, 0));
        fork_valid = 1'b1;
        step();
        fork_valid = 1'b0;
        chk("t1_fork_ignored_busy", busy, 1);
        chk("t1_fork_ignored_issued", issued_count, 10);
        finish_loop();
        // descending loop, single core
        do_fork(10, -2, 0, 0);
        req(4'h1, 4'h1, 4'h0, pk(10, 0, 0, 0));
        req(4'h1, 4'h1, 4'h0, pk(8, 0, 0, 0));
        req(4'h1, 4'h1, 4'h0, pk(6, 0, 0, 0));
        req(4'h1, 4'h1, 4'h0, pk(4, 0, 0, 0));
        req(4'h1, 4'h1, 4'h0, pk(2, 0, 0, 0));
        req(4'h1, 4'h1, 4'h1, pk(0, 0, 0, 0));
        chk("t2_issued", issued_count, 5);
        finish_loop();
        // sparse requesters, then reset mid-RUN
        do_fork(7, 3, 100, 0);
        req(4'hA, 4'hA, 4'h0, pk(0, 7, 0, 10));
        req(4'h1, 4'h1, 4'h0, pk(13, 0, 0, 0));
        chk("t3_issued", issued_count, 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req_valid = '1;
        #1;
        chk("t5_req_ready", req_ready, 0);
        chk("t5_issued", issued_count, 0);
        chk("t5_busy", busy, 0);
        chk("t5_join", join_valid, 0);
        chk("t5_fork_ready", fork_ready, 1);
        step();
        req_valid = '0;
        // empty loop and partial idle
        do_fork(5, 1, 5, 0);
        req(4'h1, 4'h1, 4'h1, pk(5, 0, 0, 0));
        chk("t4_issued", issued_count, 0);
        chk("t4_drain_busy", busy, 1);
        core_idle = 4'b0111;
        step();
        step();
        chk("t4_no_join", join_valid, 0);
        chk("t4_still_busy", busy, 1);
        finish_loop();
        // near-overflow bound with fork held throughout
        do_fork(32'h7FFFFFFC, 2, 32'h7FFFFFFF, 1);
        fork_gc = '0;
        fork_gd = 1;
        fork_limit = 100;
        chk("t6_run_fork_ready", fork_ready, 0);
        req(4'hF, 4'hF, 4'hC, pk(32'h7FFFFFFC, 32'h7FFFFFFE, 32'h80000000, 32'h80000002));
        chk("t6_issued", issued_count, 2);
        chk("t6_drain_fork_ready", fork_ready, 0);
        fork_valid = 1'b0;
        finish_loop();
        step();
        chk("queue_empty", q.size(), 0);
        chk("join_count", joins, 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
